// File: rtl/ex_stage_control.sv
// ex_stage_control: EX-stage decode, WB control register and flush/multiply/GPIO FSM.
// Optional BRANCH_DELAY_SLOT_EN: taken branches keep the next instruction (no FLUSH squash).
module ex_stage_control #(
  parameter int MULT_LAT = 4,
  parameter int GPIO_CH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [31:0]        instruction_EX,
  input  logic               zero_EX,
  output logic [3:0]         alu_op_EX,
  output logic [4:0]         shamt_EX,
  output logic [1:0]         alu_src_EX,
  output logic               rdrt_EX,
  output logic               enhilo_EX,
  output logic [1:0]         regsel_EX,
  output logic               regwrite_EX,
  output logic [1:0]         pc_src_EX,
  output logic               stall_FETCH,
  output logic [GPIO_CH-1:0] gpio_out_en,
  output logic               regwrite_WB,
  output logic [1:0]         regsel_WB,
  output logic               illegal_EX
);
  typedef enum logic [1:0] {RUN, FLUSH, MBUSY} state_t;
  state_t state;
  logic [3:0] cnt;
  logic mul_u, taken, is_mult, gpio_hit, go_flush;
  logic [5:0] op, fn;
  logic [4:0] rd, sh;
  logic unused_bits;
  assign op = instruction_EX[31:26];
  assign fn = instruction_EX[5:0];
  assign rd = instruction_EX[15:11];
  assign sh = instruction_EX[10:6];
  assign unused_bits = ^instruction_EX[25:16];
  assign gpio_hit = (rd == 5'd0) && (int'(sh) < GPIO_CH);
`ifdef BRANCH_DELAY_SLOT_EN
  assign go_flush = 1'b0;
`else
  assign go_flush = taken;
`endif
  always_comb begin
    alu_op_EX = 4'b0100;
    shamt_EX = sh;
    alu_src_EX = 2'd0;
    rdrt_EX = 1'b0;
    enhilo_EX = 1'b0;
    regsel_EX = 2'd0;
    regwrite_EX = 1'b0;
    pc_src_EX = 2'd0;
    stall_FETCH = 1'b0;
    gpio_out_en = '0;
    illegal_EX = 1'b0;
    taken = 1'b0;
    is_mult = 1'b0;
    if (!rst) begin
    end else if (state == MBUSY) begin
      stall_FETCH = 1'b1;
      enhilo_EX = 1'b1;
      alu_op_EX = mul_u ? 4'b0111 : 4'b0110;
    end else if (state == RUN && instr_valid) begin
      case (op)
        6'b000000: case (fn)
          6'b100000, 6'b100001: begin alu_op_EX = 4'b0100; regwrite_EX = 1'b1; end
          6'b100010, 6'b100011: begin alu_op_EX = 4'b0101; regwrite_EX = 1'b1; end
          6'b100100: begin alu_op_EX = 4'b0000; regwrite_EX = 1'b1; end
          6'b100101: begin alu_op_EX = 4'b0001; regwrite_EX = 1'b1; end
          6'b100111: begin alu_op_EX = 4'b0010; regwrite_EX = 1'b1; end
          6'b100110: begin alu_op_EX = 4'b0011; regwrite_EX = 1'b1; end
          6'b000000: begin alu_op_EX = 4'b1000; regwrite_EX = 1'b1; end
          6'b000010: begin
            alu_op_EX = 4'b1001;
            regwrite_EX = !gpio_hit;
            gpio_out_en = gpio_hit ? (GPIO_CH'(1) << sh) : '0;
          end
          6'b000011: begin alu_op_EX = 4'b1010; regwrite_EX = 1'b1; end
          6'b101010: begin alu_op_EX = 4'b1100; regwrite_EX = 1'b1; end
          6'b101011: begin alu_op_EX = 4'b1101; regwrite_EX = 1'b1; end
          6'b010000: begin regsel_EX = 2'd1; regwrite_EX = 1'b1; end
          6'b010010: begin regsel_EX = 2'd2; regwrite_EX = 1'b1; end
          6'b011000, 6'b011001: begin
            alu_op_EX = fn[0] ? 4'b0111 : 4'b0110;
            enhilo_EX = 1'b1;
            is_mult = 1'b1;
          end
          default: illegal_EX = 1'b1;
        endcase
        6'b001000, 6'b001001: begin alu_op_EX = 4'b0100; alu_src_EX = 2'd1; rdrt_EX = 1'b1; regwrite_EX = 1'b1; end
        6'b001010: begin alu_op_EX = 4'b1100; alu_src_EX = 2'd1; rdrt_EX = 1'b1; regwrite_EX = 1'b1; end
        6'b001100: begin alu_op_EX = 4'b0000; alu_src_EX = 2'd2; rdrt_EX = 1'b1; regwrite_EX = 1'b1; end
        6'b001101: begin alu_op_EX = 4'b0001; alu_src_EX = 2'd2; rdrt_EX = 1'b1; regwrite_EX = 1'b1; end
        6'b001110: begin alu_op_EX = 4'b0011; alu_src_EX = 2'd2; rdrt_EX = 1'b1; regwrite_EX = 1'b1; end
        6'b001111: begin alu_op_EX = 4'b1000; alu_src_EX = 2'd1; rdrt_EX = 1'b1; regwrite_EX = 1'b1; shamt_EX = 5'd16; end
        6'b000100, 6'b000101: begin
          alu_op_EX = 4'b0101;
          taken = op[0] ? !zero_EX : zero_EX;
          pc_src_EX = taken ? 2'd1 : 2'd0;
        end
        6'b000010: begin pc_src_EX = 2'd2; taken = 1'b1; end
        default: illegal_EX = 1'b1;
      endcase
    end
  end
  // The issue cycle counts toward MULT_LAT, so MBUSY lasts MULT_LAT-1 cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt <= 4'd0;
      mul_u <= 1'b0;
      regwrite_WB <= 1'b0;
      regsel_WB <= 2'd0;
    end else begin
      regwrite_WB <= regwrite_EX;
      regsel_WB <= regsel_EX;
      case (state)
        RUN: if (go_flush) state <= FLUSH;
          else if (is_mult && MULT_LAT > 1) begin
            state <= MBUSY;
            cnt <= 4'(MULT_LAT - 1);
            mul_u <= fn[0];
          end
        MBUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: doc/ex_stage_control.md
Name: ex_stage_control

Overview:
- Parametrised execute-stage control unit for the team's 3-stage MIPS pipeline (FETCH / EX / WB).
- Decodes the EX-stage instruction into ALU, HI/LO, writeback and GPIO controls.
- Registers the writeback controls for the WB stage.
- Runs a small FSM that handles taken-branch/jump flush, multi-cycle multiply stall and GPIO channel selection.

Parameters:
- MULT_LAT, 4: cycles a mult/multu occupies EX (range 1..15).
- GPIO_CH, 4: number of GPIO output channels (range 1..32).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- instr_valid  in  1  EX holds a real instruction; 0 means bubble.
- instruction_EX  in  32  instruction in EX.
- zero_EX  in  1  ALU zero flag for the current EX instruction.
- alu_op_EX  out  4  ALU operation.
- shamt_EX  out  5  shift amount.
- alu_src_EX  out  2  0 = rt, 1 = sign-extended imm, 2 = zero-extended imm.
- rdrt_EX  out  1  1 = destination is rt.
- enhilo_EX  out  1  write HI/LO.
- regsel_EX  out  2  0 = ALU, 1 = HI, 2 = LO.
- regwrite_EX  out  1  register-file write enable.
- pc_src_EX  out  2  0 = pc+4, 1 = branch target, 2 = jump target.
- stall_FETCH  out  1  hold the PC and the EX instruction.
- gpio_out_en  out  GPIO_CH  one-hot GPIO write strobe.
- regwrite_WB  out  1  registered regwrite_EX.
- regsel_WB  out  2  registered regsel_EX.
- illegal_EX  out  1  undecodable valid instruction in EX (combinational).

Behaviour:
- Reset (rst=0, async): FSM goes to RUN, multiply counter cleared, regwrite_WB=0, regsel_WB=0.
- Combinational default values (also forced while rst=0): alu_op=0100, shamt=instr[10:6], all others 0.
- R-type (op=000000), by funct:
  - add/addu 10000x: 0100
  - sub/subu 10001x: 0101
  - and 100100: 0000
  - or 100101: 0001
  - nor 100111: 0010
  - xor 100110: 0011
  - sll 000000: 1000
  - srl 000010: 1001
  - sra 000011: 1010
  - slt 101010: 1100
  - sltu 101011: 1101
  - All of the above set regwrite.
- mfhi 010000: regsel=1, regwrite=1. mflo 010010: regsel=2, regwrite=1.
- mult 011000 / multu 011001: alu 0110 / 0111, enhilo=1, no regwrite.
- I-type, all with rdrt=1 and regwrite=1:
  - addi/addiu 00100x: add, src 1
  - slti 001010: 1100, src 1
  - andi 001100: 0000, src 2
  - ori 001101: 0001, src 2
  - xori 001110: 0011, src 2
  - lui 001111: sll, src 1, shamt=16
- beq 000100 / bne 000101: alu sub. Taken when zero_EX=1 (beq) or zero_EX=0 (bne); taken sets pc_src=1.
- j 000010: pc_src=2.
- GPIO write: srl with rd=0 and shamt<GPIO_CH drives gpio_out_en[shamt]=1 and suppresses regwrite. If shamt≥GPIO_CH, the instruction is a plain srl to $0.
- Any other valid encoding: bubble (all enables 0) and illegal_EX=1.
- FSM states:
  - RUN: normal decode.
    - Taken branch or j → FLUSH.
    - mult/multu with MULT_LAT>1 → MBUSY, counter=MULT_LAT-1.
  - FLUSH (one cycle): EX instruction squashed (all enables, pc_src, gpio, illegal = 0), stall_FETCH=0 → RUN.
  - MBUSY: stall_FETCH=1 and EX treated as a bubble.
    - enhilo_EX held at 1 with the mult alu_op, so the datapath completes the multiply.
    - Counter decrements each cycle; → RUN when counter=1 is consumed.
    - Total EX occupancy is exactly MULT_LAT cycles.
- instr_valid=0 in RUN: bubble, no state change.
- WB register: regwrite_WB/regsel_WB load the EX values every cycle, including bubble values.
- Reset mid-MBUSY or mid-FLUSH aborts to RUN immediately, with no stray strobes.

Optional Feature:
- BRANCH_DELAY_SLOT_EN defined:
  - Taken branch/jump stays in RUN; the next instruction executes normally (MIPS delay slot).
  - The FLUSH state is unreachable.
- Not defined: one-cycle FLUSH squash as above.

Test Plan:
- add $3,$1,$2 (0x00221820) valid → alu_op=0100, regwrite_EX=1; next cycle regwrite_WB=1, regsel_WB=0.
- bne with zero_EX=0 → pc_src_EX=1. Next cycle, valid ori in EX is squashed (regwrite_EX=0). With BRANCH_DELAY_SLOT_EN, the ori writes.
- mult, MULT_LAT=4 → stall_FETCH=1 and enhilo_EX=1 for 3 cycles after issue, back to RUN on the 5th cycle. Then mflo → regsel_EX=2, regwrite_EX=1.
- srl rd=0 shamt=2, GPIO_CH=4 → gpio_out_en=0100, regwrite_EX=0. With shamt=5 → gpio_out_en=0, regwrite_EX=1.
- lui → shamt_EX=16, alu_op=1000, alu_src_EX=1, rdrt_EX=1. Opcode 0x3F valid → illegal_EX=1, all enables 0.
- rst pulled low during the 2nd MBUSY cycle → stall_FETCH=0 at once, WB regs 0. After release, add decodes normally.
